ballot_capture: RTL and testbench

//   Voter-facing front end of the voting machine. Sits directly upstream of the vote counter.
//   - Synchronises and debounces the raw option and confirm/cancel buttons.
//   - Runs one voter session at a time: select option, confirm, commit.
//   - Emits exactly one registered one-hot vote pulse per completed session, then locks out

---
 rtl/ballot_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/ballot_capture.sv | 147 ++++++++++++++
 tb/tb_ballot_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ballot_pkg.sv
// Shared types and default sizing for the ballot capture front end.
package ballot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SELECTED = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_LOCKED   = 3'd4
  } ballot_state_t;

  localparam int NUM_OPT_DEF      = 4;
  localparam int DEBOUNCE_CYC_DEF = 4;
  localparam int TIMEOUT_CYC_DEF  = 255;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, stability counter, registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // level flips on the DEBOUNCE_CYC-th consecutive synced sample that disagrees
  // with it; rise follows one cycle later from the delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ballot_capture.sv
// Voter session controller: debounced buttons in, one legal one-hot vote pulse out
// per officer-armed session.
module ballot_capture
  import ballot_pkg::*;
#(
  parameter int NUM_OPT      = NUM_OPT_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               session_en,
  input  logic [NUM_OPT-1:0] btn,
  input  logic               confirm_btn,
  input  logic               cancel_btn,
  output logic [NUM_OPT-1:0] vote_out,
  output logic               vote_valid,
  output logic [NUM_OPT-1:0] selection,
  output logic               booth_ready,
  output logic               timeout_err,
  output logic [7:0]         votes_cast,
  output logic [2:0]         state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [NUM_OPT-1:0] opt_rise;
  logic [NUM_OPT-1:0] opt_level;
  logic               confirm_rise, confirm_level;
  logic               cancel_rise, cancel_level;
  logic               unused_levels;

  for (genvar i = 0; i < NUM_OPT; i++) begin : g_opt
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .reset_n(reset_n), .raw(btn[i]), .level(opt_level[i]), .rise(opt_rise[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_confirm (
    .clk(clk), .reset_n(reset_n), .raw(confirm_btn), .level(confirm_level), .rise(confirm_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cancel (
    .clk(clk), .reset_n(reset_n), .raw(cancel_btn), .level(cancel_level), .rise(cancel_rise)
  );

  assign unused_levels = ^{opt_level, confirm_level, cancel_level};

  ballot_state_t      state_q, state_d;
  logic [NUM_OPT-1:0] sel_d, vote_d;
  logic               valid_d, tmo_err_d, ready_d, tick;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [7:0]         cast_d;

  assign state_dbg = state_q;

  // vote_valid is a single-cycle strobe with no back-pressure: it is high exactly
  // when vote_out carries a one-hot vote, and the consumer must take it that cycle.
  always_comb begin
    state_d   = state_q;
    sel_d     = selection;
    vote_d    = '0;
    valid_d   = 1'b0;
    tmo_err_d = 1'b0;
    tmo_d     = tmo_q;
    cast_d    = votes_cast;
    tick      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (session_en) begin
          state_d = ST_ARMED;
          tmo_d   = '0;
        end
      end
      ST_ARMED, ST_SELECTED: begin
        if (!session_en) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (opt_rise != '0) begin
          // Simultaneous presses are ambiguous, so they change nothing.
          if (is_one_hot(32'(opt_rise))) begin
            state_d = ST_SELECTED;
            sel_d   = opt_rise;
            tmo_d   = '0;
          end else begin
            tick = 1'b1;
          end
        end else if (state_q == ST_SELECTED && cancel_rise) begin
          state_d = ST_ARMED;
          sel_d   = '0;
          tmo_d   = '0;
        end else if (state_q == ST_SELECTED && confirm_rise) begin
          state_d = ST_COMMIT;
          tmo_d   = '0;
        end else begin
          tick = 1'b1;
        end
      end
      ST_COMMIT: begin
        vote_d  = selection;
        valid_d = 1'b1;
        sel_d   = '0;
        state_d = ST_LOCKED;
        if (votes_cast != 8'hff) cast_d = votes_cast + 8'd1;
      end
      ST_LOCKED: begin
        sel_d = '0;
        if (!session_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_err_d = 1'b1;
        state_d   = ST_LOCKED;
        sel_d     = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    ready_d = (state_d == ST_ARMED) || (state_d == ST_SELECTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      selection   <= '0;
      vote_out    <= '0;
      vote_valid  <= 1'b0;
      timeout_err <= 1'b0;
      booth_ready <= 1'b0;
      votes_cast  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      selection   <= sel_d;
      vote_out    <= vote_d;
      vote_valid  <= valid_d;
      timeout_err <= tmo_err_d;
      booth_ready <= ready_d;
      votes_cast  <= cast_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_ballot_capture.sv
// Directed bench for ballot_capture with a vote scoreboard.
module tb_ballot_capture;
  import ballot_pkg::*;

  localparam int NUM_OPT = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               session_en;
  logic [NUM_OPT-1:0] btn;
  logic               confirm_btn;
  logic               cancel_btn;
  logic [NUM_OPT-1:0] vote_out;
  logic               vote_valid;
  logic [NUM_OPT-1:0] selection;
  logic               booth_ready;
  logic               timeout_err;
  logic [7:0]         votes_cast;
  logic [2:0]         state_dbg;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [NUM_OPT-1:0] exp_q[$];

  ballot_capture #(.NUM_OPT(NUM_OPT), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset_n(reset_n), .session_en(session_en), .btn(btn),
    .confirm_btn(confirm_btn), .cancel_btn(cancel_btn), .vote_out(vote_out),
    .vote_valid(vote_valid), .selection(selection), .booth_ready(booth_ready),
    .timeout_err(timeout_err), .votes_cast(votes_cast), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NUM_OPT-1:0] mask);
    btn = mask;
    cycles(8);
    btn = '0;
    cycles(2);
  endtask

  task automatic press_ctl(input logic conf, input logic canc);
    confirm_btn = conf;
    cancel_btn  = canc;
    cycles(8);
    confirm_btn = 1'b0;
    cancel_btn  = 1'b0;
    cycles(2);
  endtask

  task automatic rearm();
    session_en = 1'b0;
    cycles(2);
    session_en = 1'b1;
    cycles(1);
  endtask

  // scoreboard: every vote pulse must match the oldest expected vote
  always @(negedge clk) begin
    if (vote_valid || vote_out != '0) begin
      if (exp_q.size() == 0) begin
        check("vote_unexpected", 32'(vote_valid), 32'(0));
      end else begin
        check("vote_valid", 32'(vote_valid), 32'(1));
        check("vote_out", 32'(vote_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    logic [NUM_OPT-1:0] m;
    reset_n     = 1'b0;
    session_en  = 1'b0;
    btn         = '0;
    confirm_btn = 1'b0;
    cancel_btn  = 1'b0;
    cycles(3);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_vote", 32'({vote_out, vote_valid, timeout_err}), 32'(0));
    check("rst_sel", 32'(selection), 32'(0));
    check("rst_ready", 32'(booth_ready), 32'(0));
    check("rst_cast", 32'(votes_cast), 32'(0));
    reset_n = 1'b1;
    cycles(2);

    // 1: basic vote with exact debounce latency
    session_en = 1'b1;
    cycles(1);
    check("t1_armed", 32'(state_dbg), 32'(ST_ARMED));
    check("t1_ready", 32'(booth_ready), 32'(1));
    btn = 4'b0100;
    cycles(7);
    check("t1_sel_early", 32'(selection), 32'(0));
    cycles(1);
    check("t1_sel", 32'(selection), 32'(4'b0100));
    check("t1_selected", 32'(state_dbg), 32'(ST_SELECTED));
    btn = '0;
    cycles(2);
    exp_q.push_back(4'b0100);
    confirm_btn = 1'b1;
    cycles(8);
    check("t1_commit", 32'(state_dbg), 32'(ST_COMMIT));
    check("t1_no_vote_yet", 32'(vote_valid), 32'(0));
    confirm_btn = 1'b0;
    cycles(1);
    check("t1_vote", 32'(vote_out), 32'(4'b0100));
    check("t1_valid", 32'(vote_valid), 32'(1));
    check("t1_cast", 32'(votes_cast), 32'(1));
    check("t1_ready_low", 32'(booth_ready), 32'(0));
    cycles(1);
    check("t1_valid_pulse", 32'(vote_valid), 32'(0));
    check("t1_sel_clr", 32'(selection), 32'(0));
    cycles(3);
    check("t1_locked", 32'(state_dbg), 32'(ST_LOCKED));
    rearm();
    check("t2_armed", 32'(state_dbg), 32'(ST_ARMED));

    // 2: glitch rejected, last press wins
    btn = 4'b0001;
    cycles(2);
    btn = '0;
    cycles(6);
    check("t2_glitch_sel", 32'(selection), 32'(0));
    press(4'b1000);
    check("t2_sel3", 32'(selection), 32'(4'b1000));
    press(4'b0010);
    check("t2_sel1", 32'(selection), 32'(4'b0010));
    exp_q.push_back(4'b0010);
    press_ctl(1'b1, 1'b0);
    check("t2_cast", 32'(votes_cast), 32'(2));
    check("t2_locked", 32'(state_dbg), 32'(ST_LOCKED));
    rearm();

    // 3: simultaneous options ignored, cancel, confirm ignored in ARMED
    press(4'b1100);
    check("t3_multi_sel", 32'(selection), 32'(0));
    check("t3_multi_st", 32'(state_dbg), 32'(ST_ARMED));
    press(4'b0001);
    check("t3_sel0", 32'(selection), 32'(4'b0001));
    press_ctl(1'b0, 1'b1);
    check("t3_cancel_sel", 32'(selection), 32'(0));
    check("t3_cancel_st", 32'(state_dbg), 32'(ST_ARMED));
    press_ctl(1'b1, 1'b0);
    check("t3_confirm_st", 32'(state_dbg), 32'(ST_ARMED));
    check("t3_cast", 32'(votes_cast), 32'(2));
    session_en = 1'b0;
    cycles(2);
    check("t3_idle", 32'(state_dbg), 32'(ST_IDLE));

    // 4: idle timeout
    session_en = 1'b1;
    cycles(1);
    check("t4_armed", 32'(state_dbg), 32'(ST_ARMED));
    n = 0;
    while (n < 40 && !timeout_err) begin
      cycles(1);
      n++;
    end
    check("t4_tmo_cycles", 32'(n), 32'(20));
    check("t4_tmo_err", 32'(timeout_err), 32'(1));
    check("t4_locked", 32'(state_dbg), 32'(ST_LOCKED));
    check("t4_ready", 32'(booth_ready), 32'(0));
    cycles(1);
    check("t4_tmo_pulse", 32'(timeout_err), 32'(0));
    rearm();
    check("t4_rearmed", 32'(state_dbg), 32'(ST_ARMED));

    // 5: cancel beats confirm; officer drop aborts
    press(4'b0010);
    check("t5_sel", 32'(selection), 32'(4'b0010));
    press_ctl(1'b1, 1'b1);
    check("t5_both_st", 32'(state_dbg), 32'(ST_ARMED));
    check("t5_both_sel", 32'(selection), 32'(0));
    press(4'b0100);
    check("t5_sel2", 32'(state_dbg), 32'(ST_SELECTED));
    session_en = 1'b0;
    cycles(1);
    check("t5_drop_st", 32'(state_dbg), 32'(ST_IDLE));
    check("t5_drop_sel", 32'(selection), 32'(0));
    check("t5_drop_tmo", 32'(timeout_err), 32'(0));
    check("t5_cast", 32'(votes_cast), 32'(2));

    // 6: asynchronous reset mid-session, then saturation
    session_en = 1'b1;
    cycles(1);
    press(4'b1000);
    check("t6_selected", 32'(state_dbg), 32'(ST_SELECTED));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("t6_rst_sel", 32'(selection), 32'(0));
    check("t6_rst_cast", 32'(votes_cast), 32'(0));
    check("t6_rst_ready", 32'(booth_ready), 32'(0));
    cycles(2);
    reset_n = 1'b1;
    for (int s = 0; s < 256; s++) begin
      session_en = 1'b1;
      cycles(1);
      m = 4'b0001 << (s % 4);
      press(m);
      exp_q.push_back(m);
      press_ctl(1'b1, 1'b0);
      if (s == 254) check("t6_cast_255", 32'(votes_cast), 32'(255));
      session_en = 1'b0;
      cycles(2);
    end
    check("t6_cast_sat", 32'(votes_cast), 32'(255));
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
